// File: rtl/chacha20_key_regbank.sv
// Key/nonce/counter register bank for the ChaCha20 core, plus the command
// handshake FSM (init/next pulse, wait for core_ready low then high, timeout).
module chacha20_key_regbank #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NAME_WORD      = 32'h6332306b
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cs,
  input  logic         we,
  input  logic [7:0]   addr,
  input  logic [31:0]  write_data,
  output logic [31:0]  read_data,
  input  logic         core_ready,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] key,
  output logic [95:0]  nonce,
  output logic [31:0]  ctr,
  output logic         key_complete
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   key_w [8];
  logic [31:0]   nonce_w [3];
  logic [7:0]    mask;
  logic          lock;
  logic [4:0]    err, err_set, err_clr;
  logic          busy, timeout;
  logic [31:0]   rd_val;

  logic wr, rd;
  logic is_name, is_ctrl, is_status, is_err, is_key, is_ctr, is_nonce, mapped;
  logic cmd_req, cmd_ok, zeroize;

  assign wr        = cs & we;
  assign rd        = cs & ~we;
  assign is_name   = (addr == 8'h00);
  assign is_ctrl   = (addr == 8'h08);
  assign is_status = (addr == 8'h09);
  assign is_err    = (addr == 8'h0A);
  assign is_key    = (addr[7:3] == 5'b00010);
  assign is_ctr    = (addr == 8'h20);
  assign is_nonce  = (addr == 8'h21) | (addr == 8'h22) | (addr == 8'h23);
  assign mapped    = is_name | is_ctrl | is_status | is_err | is_key | is_ctr | is_nonce;

  assign busy         = (state != IDLE);
  assign key_complete = &mask;
  assign key          = {key_w[0], key_w[1], key_w[2], key_w[3],
                         key_w[4], key_w[5], key_w[6], key_w[7]};
  assign nonce        = {nonce_w[0], nonce_w[1], nonce_w[2]};

  // Zeroize in the same CTRL write overrides any command bits.
  assign zeroize = wr & is_ctrl & write_data[3];
  assign cmd_req = wr & is_ctrl & ~write_data[3] & (write_data[0] | write_data[1]);
  assign cmd_ok  = cmd_req & key_complete & core_ready & ~busy;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ok) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (!core_ready) begin
          state_nxt = WAIT_HIGH;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (core_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (zeroize) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    err_set    = '0;
    err_set[0] = wr & is_key & (lock | busy);
    err_set[1] = (wr & (is_ctr | is_nonce) & busy) | (cmd_req & (busy | ~core_ready));
    err_set[2] = cmd_req & ~key_complete;
    err_set[3] = cs & ~mapped;
    err_set[4] = timeout;
    err_clr    = (wr & is_err) ? write_data[4:0] : 5'b0;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      8'h00:   rd_val = NAME_WORD;
      8'h08:   rd_val = {29'b0, lock, 2'b0};
      8'h09:   rd_val = {27'b0, busy, |err, lock, key_complete, core_ready};
      8'h0A:   rd_val = {27'b0, err};
      8'h20:   rd_val = ctr;
      8'h21:   rd_val = nonce_w[0];
      8'h22:   rd_val = nonce_w[1];
      8'h23:   rd_val = nonce_w[2];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      mask      <= '0;
      lock      <= 1'b0;
      err       <= '0;
      ctr       <= '0;
      for (int i = 0; i < 8; i++) key_w[i] <= '0;
      for (int i = 0; i < 3; i++) nonce_w[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      core_init <= cmd_ok & write_data[0];
      core_next <= cmd_ok & ~write_data[0] & write_data[1];
      err       <= (err & ~err_clr) | err_set;
      if (rd) read_data <= rd_val;
      if (zeroize) begin
        mask <= '0;
        lock <= 1'b0;
        ctr  <= '0;
        for (int i = 0; i < 8; i++) key_w[i] <= '0;
        for (int i = 0; i < 3; i++) nonce_w[i] <= '0;
      end else begin
        if (wr & is_key & ~lock & ~busy) begin
          key_w[addr[2:0]] <= write_data;
          mask[addr[2:0]]  <= 1'b1;
        end
        if (wr & is_ctrl & write_data[2]) lock <= 1'b1;
        if (wr & ~busy) begin
          if (addr == 8'h20) ctr        <= write_data;
          if (addr == 8'h21) nonce_w[0] <= write_data;
          if (addr == 8'h22) nonce_w[1] <= write_data;
          if (addr == 8'h23) nonce_w[2] <= write_data;
        end
      end
    end
  end

endmodule

// File: doc/chacha20_key_regbank.md
Name: chacha20_key_regbank

Overview:
- Memory-mapped responder for the ChaCha20 key/control write bus (cs/we/addr/write_data/read_data) driven by the system key-transfer FSM.
- Holds the 256-bit key, 96-bit nonce and 32-bit block counter, and tracks key-word completeness and write-lock.
- Issues one-cycle init/next pulses to the ChaCha20 core and tracks core busy through a handshake FSM with timeout.
- Sits between the system controller and the ChaCha20 round core.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles to wait for core_ready to drop after a command pulse.
- NAME_WORD, 32'h6332306b: constant returned at address 0x00.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset (see Behaviour)
- cs  in  1  chip select
- we  in  1  write enable; cs=1,we=1 is a write, cs=1,we=0 is a read
- addr  in  8  register address
- write_data  in  32  write data
- read_data  out  32  registered read data
- core_ready  in  1  core idle/ready
- core_init  out  1  one-cycle init pulse
- core_next  out  1  one-cycle next pulse
- key  out  256  KEY0 in [255:224] .. KEY7 in [31:0]
- nonce  out  96  NONCE0 in [95:64] .. NONCE2 in [31:0]
- ctr  out  32  block counter
- key_complete  out  1  all 8 key words written since the last reset/zeroize

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All registers, outputs, mask, lock, err and FSM are cleared to 0 / IDLE.
- Address map:
  - 0x00 NAME (RO).
  - 0x08 CTRL (W): bit0 init, bit1 next, bit2 lock (set-only), bit3 zeroize. Reads return {29'b0, lock, 2'b0}.
  - 0x09 STATUS (RO): {27'b0, busy, |err, lock, key_complete, core_ready}.
  - 0x0A ERR: RO value; write-1-to-clear. Bits: 0 locked-write, 1 cmd-while-busy/not-ready, 2 cmd-with-incomplete-key, 3 unmapped access, 4 timeout.
  - 0x10–0x17 KEY0–7: write-only; reads return 0.
  - 0x20 CTR, 0x21–0x23 NONCE0–2: read/write.
- Reads:
  - read_data is updated the cycle after the cs&&!we request.
  - read_data holds its value when there is no read.
  - An unmapped read returns 0 and sets err[3].
- Key writes:
  - A write to 0x10+i stores the word and sets mask[i].
  - key_complete = &mask.
  - If lock=1 or busy=1: the write is ignored and err[0] is set.
  - Rewriting an already-set index is permitted.
- NONCE/CTR writes: ignored if busy, and set err[1].
- Lock: cleared only by reset or zeroize.
- Zeroize:
  - On the cycle after the write, key, nonce, ctr, mask and lock are cleared and the FSM is forced to IDLE.
  - Any in-flight pulse is suppressed.
  - err is not cleared.
- Commands:
  - A CTRL write with bit0 or bit1 is accepted only if key_complete, core_ready and !busy. Otherwise it is dropped and sets err[2] (incomplete key) or err[1].
  - If both bits are set, init wins and next is silently dropped.
  - An accepted command pulses core_init/core_next high for exactly the one cycle after the write, and busy is asserted in that same cycle.
  - If zeroize is set in the same write, zeroize wins and no command is issued.
- Command FSM:
  - IDLE: an accepted command → WAIT_LOW; counter=0.
  - WAIT_LOW:
    - core_ready==0 → WAIT_HIGH.
    - counter==TIMEOUT_CYCLES-1 → IDLE, set err[4].
    - Otherwise counter+1.
  - WAIT_HIGH: core_ready==1 → IDLE.
  - busy = (state != IDLE).
- Writes in the same cycle as an err W1C: new error events take priority over the clear.

Test Plan:
- Reset, read 0x00 → read_data=32'h6332306b one cycle later; read 0x09 with core_ready=1 → 32'h1.
- Write KEY0..KEY7 = 32'h00010203+i → key_complete rises after the 8th write; key[255:224]=32'h00010203; read 0x13 → 0.
- Write CTRL=1 with all keys loaded and core_ready=1 → core_init high exactly 1 cycle. Drop core_ready 3 cycles, raise it → busy clears one cycle after core_ready=1. A second CTRL=1 while busy → no pulse, err[1]=1.
- Write CTRL=1 after only 7 key words → no pulse, err=5'b00100. Write ERR=32'h4 → err=0.
- Write CTRL=4 (lock), then KEY2 → key unchanged, err[0]=1. Write CTRL=8 → key=0, mask=0, lock=0.
- Accept a command with core_ready held at 1 → after 64 cycles FSM returns to IDLE, err[4]=1, busy=0. Assert rst_n=0 mid-WAIT_HIGH → all outputs 0 immediately.
